// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over a shared ready/valid memory, with trap and bus-timeout paths.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT     = 16,
  parameter int unsigned TO_W            = 5,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] alu_op,
  output logic [1:0] mem_size,
  output logic       mem_unsigned,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       fault
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_ALU_WB, S_JALR_ADDR,
    S_JAL, S_BRANCH, S_MEM_ADDR, S_MEM_READ, S_MEM_WRITE, S_MEM_WB, S_FAULT, S_TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      cause_q, cause_d;

  state_e     dec_state;
  logic [1:0] dec_cause;
  logic       taken;
  logic       mem_wait;
  logic       timeout_hit;

  // funct7 is consumed by the ALU decoder, not by the sequencer
  logic unused_funct7;
  assign unused_funct7 = ^funct7;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    dec_state = S_TRAP;
    dec_cause = 2'b00;
    case (opcode)
      OP_R:      dec_state = S_EXEC_R;
      OP_IMM:    dec_state = S_EXEC_I;
      OP_LOAD:   if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) dec_state = S_MEM_ADDR;
                 else dec_cause = 2'b01;
      OP_STORE:  if (funct3 inside {3'b000, 3'b001, 3'b010}) dec_state = S_MEM_ADDR;
                 else dec_cause = 2'b01;
      OP_BRANCH: if (!(funct3 inside {3'b010, 3'b011})) dec_state = S_BRANCH;
                 else dec_cause = 2'b01;
      OP_JAL:    dec_state = S_JAL;
      OP_JALR:   dec_state = S_JALR_ADDR;
      OP_LUI:    dec_state = S_LUI;
      OP_AUIPC:  dec_state = S_AUIPC;
      OP_FENCE:  dec_state = S_FETCH;
      OP_SYSTEM: dec_cause = 2'b10;
      default:   dec_cause = 2'b00;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  assign mem_wait    = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && !mem_ready && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_state != S_TRAP) begin
          state_d = dec_state;
        end else if (TRAP_ON_ILLEGAL) begin
          state_d = S_TRAP;
          cause_d = dec_cause;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_JALR_ADDR: state_d = S_JAL;
      S_JAL:       state_d = S_ALU_WB;
      S_BRANCH:    state_d = S_FETCH;
      S_MEM_ADDR:  state_d = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_MEM_WB:    state_d = S_FETCH;
      S_FAULT:     state_d = S_FAULT;
      S_TRAP:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
    if (timeout_hit) state_d = S_FAULT;
  end

  // Counter restarts on every state change so each wait state gets a full budget
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || !mem_wait) cnt_d = '0;
    else if (!mem_ready)                   cnt_d = cnt_q + TO_W'(1);
  end

  // Outputs are forced low while rst is held so no enable leaks during an async reset
  always_comb begin
    mem_req      = 1'b0;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    RegWrite     = 1'b0;
    alu_op       = 2'b00;
    mem_size     = 2'b00;
    mem_unsigned = 1'b0;
    trap         = 1'b0;
    trap_cause   = 2'b00;
    fault        = 1'b0;
    if (rst) begin
      trap_cause = (state_q == S_FAULT) ? 2'b00 : cause_q;
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        S_EXEC_R: begin
          ALUSrcA = 2'b10;
          alu_op  = 2'b10;
        end
        S_EXEC_I: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          alu_op  = 2'b10;
        end
        S_LUI: begin
          ALUSrcB = 2'b01;
          alu_op  = 2'b10;
        end
        S_AUIPC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          alu_op  = 2'b10;
        end
        S_ALU_WB:    RegWrite = 1'b1;
        S_JALR_ADDR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_JAL: begin
          PCWrite = 1'b1;
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        S_BRANCH: begin
          ALUSrcA = 2'b10;
          alu_op  = 2'b01;
          PCWrite = taken;
        end
        S_MEM_ADDR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEM_READ, S_MEM_WRITE: begin
          mem_req      = 1'b1;
          AdrSrc       = 1'b1;
          MemWrite     = (state_q == S_MEM_WRITE);
          mem_size     = funct3[1:0];
          mem_unsigned = funct3[2];
        end
        S_MEM_WB: begin
          ResultSrc    = 2'b01;
          RegWrite     = 1'b1;
          mem_size     = funct3[1:0];
          mem_unsigned = funct3[2];
        end
        S_FAULT: fault = 1'b1;
        S_TRAP: begin
          PCWrite   = 1'b1;
          ResultSrc = 2'b11;
          trap      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle vector table plus hand sequences for
// timeout, async reset mid-access and the trap-disabled variant.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] alu_op;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       trap;
    logic [1:0] trap_cause;
    logic       fault;
  } outs_t;

  typedef enum int {
    T_RST, T_FETCH, T_DECODE, T_EXR, T_EXI, T_LUI, T_AUIPC, T_WB, T_JALRA,
    T_JAL, T_BR, T_MADDR, T_MRD, T_MWR, T_MWB, T_FAULT, T_TRAP
  } tag_e;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       z, lt, ltu, rdy;
    tag_e       tag;
    logic       pcw, irw;
    logic [1:0] tc;
  } vec_t;

  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, OPL = 7'b0000011;
  localparam logic [6:0] OPS = 7'b0100011, OPB = 7'b1100011, OPJ = 7'b1101111;
  localparam logic [6:0] OPJR = 7'b1100111, OPLUI = 7'b0110111, OPAU = 7'b0010111;
  localparam logic [6:0] OPF = 7'b0001111, OPSYS = 7'b1110011, OPBAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst, rst_nt;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       zero, lt, ltu, mem_ready;
  outs_t      act, act_n;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(16), .TO_W(5), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(act.mem_req), .PCWrite(act.PCWrite), .AdrSrc(act.AdrSrc),
    .MemWrite(act.MemWrite), .IRWrite(act.IRWrite), .ResultSrc(act.ResultSrc),
    .ALUSrcA(act.ALUSrcA), .ALUSrcB(act.ALUSrcB), .RegWrite(act.RegWrite),
    .alu_op(act.alu_op), .mem_size(act.mem_size), .mem_unsigned(act.mem_unsigned),
    .trap(act.trap), .trap_cause(act.trap_cause), .fault(act.fault)
  );

  mc_ctrl_fsm #(.MEM_TIMEOUT(16), .TO_W(5), .TRAP_ON_ILLEGAL(1'b0)) dut_nt (
    .clk(clk), .rst(rst_nt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(act_n.mem_req), .PCWrite(act_n.PCWrite), .AdrSrc(act_n.AdrSrc),
    .MemWrite(act_n.MemWrite), .IRWrite(act_n.IRWrite), .ResultSrc(act_n.ResultSrc),
    .ALUSrcA(act_n.ALUSrcA), .ALUSrcB(act_n.ALUSrcB), .RegWrite(act_n.RegWrite),
    .alu_op(act_n.alu_op), .mem_size(act_n.mem_size), .mem_unsigned(act_n.mem_unsigned),
    .trap(act_n.trap), .trap_cause(act_n.trap_cause), .fault(act_n.fault)
  );

  // Expected control word per state; Mealy fields and trap_cause come from the row
  function automatic outs_t base(input tag_e t, input logic [2:0] f3);
    outs_t o;
    o = '0;
    case (t)
      T_FETCH:  begin o.mem_req = 1'b1; o.ALUSrcB = 2'b10; o.ResultSrc = 2'b10; end
      T_DECODE: begin o.ALUSrcA = 2'b01; o.ALUSrcB = 2'b01; end
      T_EXR:    begin o.ALUSrcA = 2'b10; o.alu_op = 2'b10; end
      T_EXI:    begin o.ALUSrcA = 2'b10; o.ALUSrcB = 2'b01; o.alu_op = 2'b10; end
      T_LUI:    begin o.ALUSrcB = 2'b01; o.alu_op = 2'b10; end
      T_AUIPC:  begin o.ALUSrcA = 2'b01; o.ALUSrcB = 2'b01; o.alu_op = 2'b10; end
      T_WB:     o.RegWrite = 1'b1;
      T_JALRA:  begin o.ALUSrcA = 2'b10; o.ALUSrcB = 2'b01; end
      T_JAL:    begin o.ALUSrcA = 2'b01; o.ALUSrcB = 2'b10; end
      T_BR:     begin o.ALUSrcA = 2'b10; o.alu_op = 2'b01; end
      T_MADDR:  begin o.ALUSrcA = 2'b10; o.ALUSrcB = 2'b01; end
      T_MRD:    begin o.mem_req = 1'b1; o.AdrSrc = 1'b1; o.mem_size = f3[1:0]; o.mem_unsigned = f3[2]; end
      T_MWR:    begin o.mem_req = 1'b1; o.AdrSrc = 1'b1; o.MemWrite = 1'b1;
                      o.mem_size = f3[1:0]; o.mem_unsigned = f3[2]; end
      T_MWB:    begin o.ResultSrc = 2'b01; o.RegWrite = 1'b1; o.mem_size = f3[1:0]; o.mem_unsigned = f3[2]; end
      T_FAULT:  o.fault = 1'b1;
      T_TRAP:   begin o.ResultSrc = 2'b11; o.trap = 1'b1; end
      default:  o = '0;
    endcase
    return o;
  endfunction

  function automatic vec_t R(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                             input logic l, input logic lu, input logic rdy, input tag_e tag,
                             input logic pcw, input logic irw, input logic [1:0] tc);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.z = z; v.lt = l; v.ltu = lu; v.rdy = rdy;
    v.tag = tag; v.pcw = pcw; v.irw = irw; v.tc = tc;
    return v;
  endfunction

  task automatic check(input string nm, input outs_t got, input outs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic run(input vec_t v, input string nm, input bit nt);
    outs_t e;
    @(negedge clk);
    opcode = v.opc; funct3 = v.f3; zero = v.z; lt = v.lt; ltu = v.ltu; mem_ready = v.rdy;
    #2;
    e = base(v.tag, v.f3);
    e.PCWrite = v.pcw; e.IRWrite = v.irw; e.trap_cause = v.tc;
    check(nm, nt ? act_n : act, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rst_nt = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;

    // ALU, upper-immediate and branch flows
    vecs.push_back(R(OPR, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));
    vecs.push_back(R(OPR, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPR, 3'd0, 0, 0, 0, 1, T_EXR, 0, 0, 2'd0));
    vecs.push_back(R(OPR, 3'd0, 0, 0, 0, 1, T_WB, 0, 0, 2'd0));
    vecs.push_back(R(OPI, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));
    vecs.push_back(R(OPI, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPI, 3'd0, 0, 0, 0, 1, T_EXI, 0, 0, 2'd0));
    vecs.push_back(R(OPI, 3'd0, 0, 0, 0, 1, T_WB, 0, 0, 2'd0));
    vecs.push_back(R(OPLUI, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));
    vecs.push_back(R(OPLUI, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPLUI, 3'd0, 0, 0, 0, 1, T_LUI, 0, 0, 2'd0));
    vecs.push_back(R(OPLUI, 3'd0, 0, 0, 0, 1, T_WB, 0, 0, 2'd0));
    vecs.push_back(R(OPAU, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));
    vecs.push_back(R(OPAU, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPAU, 3'd0, 0, 0, 0, 1, T_AUIPC, 0, 0, 2'd0));
    vecs.push_back(R(OPAU, 3'd0, 0, 0, 0, 1, T_WB, 0, 0, 2'd0));
    vecs.push_back(R(OPB, 3'd4, 0, 1, 0, 1, T_FETCH, 1, 1, 2'd0));   // BLT taken
    vecs.push_back(R(OPB, 3'd4, 0, 1, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPB, 3'd4, 0, 1, 0, 1, T_BR, 1, 0, 2'd0));
    vecs.push_back(R(OPB, 3'd7, 0, 0, 1, 1, T_FETCH, 1, 1, 2'd0));   // BGEU not taken
    vecs.push_back(R(OPB, 3'd7, 0, 0, 1, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPB, 3'd7, 0, 0, 1, 1, T_BR, 0, 0, 2'd0));
    vecs.push_back(R(OPB, 3'd0, 1, 0, 0, 1, T_FETCH, 1, 1, 2'd0));   // BEQ taken
    vecs.push_back(R(OPB, 3'd0, 1, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPB, 3'd0, 1, 0, 0, 1, T_BR, 1, 0, 2'd0));
    vecs.push_back(R(OPB, 3'd1, 1, 0, 0, 1, T_FETCH, 1, 1, 2'd0));   // BNE not taken
    vecs.push_back(R(OPB, 3'd1, 1, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPB, 3'd1, 1, 0, 0, 1, T_BR, 0, 0, 2'd0));
    vecs.push_back(R(OPB, 3'd5, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));   // BGE taken
    vecs.push_back(R(OPB, 3'd5, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPB, 3'd5, 0, 0, 0, 1, T_BR, 1, 0, 2'd0));
    vecs.push_back(R(OPB, 3'd6, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));   // BLTU not taken
    vecs.push_back(R(OPB, 3'd6, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPB, 3'd6, 0, 0, 0, 1, T_BR, 0, 0, 2'd0));
    // LHU with three wait states, SW with one
    vecs.push_back(R(OPL, 3'd5, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));
    vecs.push_back(R(OPL, 3'd5, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPL, 3'd5, 0, 0, 0, 1, T_MADDR, 0, 0, 2'd0));
    vecs.push_back(R(OPL, 3'd5, 0, 0, 0, 0, T_MRD, 0, 0, 2'd0));
    vecs.push_back(R(OPL, 3'd5, 0, 0, 0, 0, T_MRD, 0, 0, 2'd0));
    vecs.push_back(R(OPL, 3'd5, 0, 0, 0, 0, T_MRD, 0, 0, 2'd0));
    vecs.push_back(R(OPL, 3'd5, 0, 0, 0, 1, T_MRD, 0, 0, 2'd0));
    vecs.push_back(R(OPL, 3'd5, 0, 0, 0, 1, T_MWB, 0, 0, 2'd0));
    vecs.push_back(R(OPS, 3'd2, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));
    vecs.push_back(R(OPS, 3'd2, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPS, 3'd2, 0, 0, 0, 1, T_MADDR, 0, 0, 2'd0));
    vecs.push_back(R(OPS, 3'd2, 0, 0, 0, 0, T_MWR, 0, 0, 2'd0));
    vecs.push_back(R(OPS, 3'd2, 0, 0, 0, 1, T_MWR, 0, 0, 2'd0));
    // Slow fetch, then JALR and JAL
    vecs.push_back(R(OPJR, 3'd0, 0, 0, 0, 0, T_FETCH, 0, 0, 2'd0));
    vecs.push_back(R(OPJR, 3'd0, 0, 0, 0, 0, T_FETCH, 0, 0, 2'd0));
    vecs.push_back(R(OPJR, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));
    vecs.push_back(R(OPJR, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPJR, 3'd0, 0, 0, 0, 1, T_JALRA, 0, 0, 2'd0));
    vecs.push_back(R(OPJR, 3'd0, 0, 0, 0, 1, T_JAL, 1, 0, 2'd0));
    vecs.push_back(R(OPJR, 3'd0, 0, 0, 0, 1, T_WB, 0, 0, 2'd0));
    vecs.push_back(R(OPJ, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));
    vecs.push_back(R(OPJ, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPJ, 3'd0, 0, 0, 0, 1, T_JAL, 1, 0, 2'd0));
    vecs.push_back(R(OPJ, 3'd0, 0, 0, 0, 1, T_WB, 0, 0, 2'd0));
    // FENCE is a NOP; SB stores a byte
    vecs.push_back(R(OPF, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));
    vecs.push_back(R(OPF, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPS, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));
    vecs.push_back(R(OPS, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPS, 3'd0, 0, 0, 0, 1, T_MADDR, 0, 0, 2'd0));
    vecs.push_back(R(OPS, 3'd0, 0, 0, 0, 1, T_MWR, 0, 0, 2'd0));
    // Trap entries; trap_cause persists until the next trap
    vecs.push_back(R(OPS, 3'd3, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));
    vecs.push_back(R(OPS, 3'd3, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPS, 3'd3, 0, 0, 0, 1, T_TRAP, 1, 0, 2'd1));
    vecs.push_back(R(OPSYS, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd1));
    vecs.push_back(R(OPSYS, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd1));
    vecs.push_back(R(OPSYS, 3'd0, 0, 0, 0, 1, T_TRAP, 1, 0, 2'd2));
    vecs.push_back(R(OPBAD, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd2));
    vecs.push_back(R(OPBAD, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd2));
    vecs.push_back(R(OPBAD, 3'd0, 0, 0, 0, 1, T_TRAP, 1, 0, 2'd0));
    vecs.push_back(R(OPL, 3'd3, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0));
    vecs.push_back(R(OPL, 3'd3, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0));
    vecs.push_back(R(OPL, 3'd3, 0, 0, 0, 1, T_TRAP, 1, 0, 2'd1));
    vecs.push_back(R(OPSYS, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd1));
    vecs.push_back(R(OPSYS, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd1));
    vecs.push_back(R(OPSYS, 3'd0, 0, 0, 0, 1, T_TRAP, 1, 0, 2'd2));
    vecs.push_back(R(OPB, 3'd2, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd2));
    vecs.push_back(R(OPB, 3'd2, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd2));
    vecs.push_back(R(OPB, 3'd2, 0, 0, 0, 1, T_TRAP, 1, 0, 2'd1));

    // Reset state: every output low while rst is held
    repeat (2) @(negedge clk);
    run(R(OPR, 3'd0, 0, 0, 0, 0, T_RST, 0, 0, 2'd0), "reset_outputs", 1'b0);
    run(R(OPR, 3'd0, 0, 0, 0, 0, T_RST, 0, 0, 2'd0), "reset_outputs_nt", 1'b1);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // Fetch timeout: 16 waiting cycles, then terminal FAULT
    for (int i = 0; i < 16; i++)
      run(R(OPR, 3'd0, 0, 0, 0, 0, T_FETCH, 0, 0, 2'd1), $sformatf("to_wait%0d", i), 1'b0);
    run(R(OPR, 3'd0, 0, 0, 0, 1, T_FAULT, 0, 0, 2'd0), "to_fault", 1'b0);
    run(R(OPR, 3'd0, 0, 0, 0, 1, T_FAULT, 0, 0, 2'd0), "to_fault_sticky", 1'b0);

    #1 rst = 1'b0;
    run(R(OPR, 3'd0, 0, 0, 0, 0, T_RST, 0, 0, 2'd0), "fault_reset", 1'b0);
    rst = 1'b1;
    // Release edge consumes one wait cycle; ready on the last allowed cycle still wins
    for (int i = 0; i < 14; i++)
      run(R(OPR, 3'd0, 0, 0, 0, 0, T_FETCH, 0, 0, 2'd0), $sformatf("edge_wait%0d", i), 1'b0);
    run(R(OPR, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0), "edge_ready_wins", 1'b0);
    run(R(OPR, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0), "edge_decode", 1'b0);
    run(R(OPR, 3'd0, 0, 0, 0, 1, T_EXR, 0, 0, 2'd0), "edge_exec", 1'b0);
    run(R(OPR, 3'd0, 0, 0, 0, 1, T_WB, 0, 0, 2'd0), "edge_wb", 1'b0);

    // Async reset in the middle of a load wait drops every enable at once
    run(R(OPL, 3'd2, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0), "mid_fetch", 1'b0);
    run(R(OPL, 3'd2, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0), "mid_decode", 1'b0);
    run(R(OPL, 3'd2, 0, 0, 0, 1, T_MADDR, 0, 0, 2'd0), "mid_maddr", 1'b0);
    run(R(OPL, 3'd2, 0, 0, 0, 0, T_MRD, 0, 0, 2'd0), "mid_mread", 1'b0);
    #1 rst = 1'b0;
    #1 check("mid_reset_immediate", act, base(T_RST, 3'd0));
    run(R(OPL, 3'd2, 0, 0, 0, 0, T_RST, 0, 0, 2'd0), "mid_reset_held", 1'b0);
    rst = 1'b1;
    run(R(OPL, 3'd2, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0), "mid_refetch", 1'b0);
    run(R(OPL, 3'd2, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0), "mid_redecode", 1'b0);

    // TRAP_ON_ILLEGAL=0: illegal and system instructions fall straight back to FETCH
    mem_ready = 1'b0;
    rst_nt = 1'b1;
    run(R(OPS, 3'd3, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0), "nt_fetch_st", 1'b1);
    run(R(OPS, 3'd3, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0), "nt_decode_st", 1'b1);
    run(R(OPS, 3'd3, 0, 0, 0, 0, T_FETCH, 0, 0, 2'd0), "nt_no_trap_st", 1'b1);
    run(R(OPSYS, 3'd0, 0, 0, 0, 1, T_FETCH, 1, 1, 2'd0), "nt_fetch_sys", 1'b1);
    run(R(OPSYS, 3'd0, 0, 0, 0, 1, T_DECODE, 0, 0, 2'd0), "nt_decode_sys", 1'b1);
    run(R(OPSYS, 3'd0, 0, 0, 0, 0, T_FETCH, 0, 0, 2'd0), "nt_no_trap_sys", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Next-generation main control FSM for the multicycle RV32I core. It drives the shared-memory datapath: PC/IR/register-file enables, ALU source muxes, result mux and ALU op class. It extends the current controller with:
- a ready/valid memory handshake and a wait-state timeout;
- all six conditional branches;
- JALR;
- load/store width control;
- FENCE as a NOP;
- a trap path for illegal or system instructions.

Parameters:
MEM_TIMEOUT, 16, cycles a memory state may wait for mem_ready before entering FAULT; 0 disables the timeout
TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT
TRAP_ON_ILLEGAL, 1, 1 = illegal/system instructions go to TRAP; 0 = treated as NOP (go to FETCH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2
ltu  in  1  unsigned rs1 < rs2
mem_ready  in  1  memory completes the access this cycle
mem_req  out  1  memory access request
PCWrite  out  1  PC write enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR write enable
ResultSrc  out  2  result mux: 00 ALUOut, 01 mem data, 10 ALU result, 11 trap vector
ALUSrcA  out  2  ALU A select: 00 PC, 01 old PC, 10 rs1
ALUSrcB  out  2  ALU B select: 00 rs2, 01 imm, 10 constant 4
RegWrite  out  1  register-file write enable
alu_op  out  2  ALU op class: 00 add, 01 sub/compare, 10 decode by funct3/funct7
mem_size  out  2  access size: 00 byte, 01 half, 10 word
mem_unsigned  out  1  zero-extend load data
trap  out  1  one-cycle pulse on trap entry
trap_cause  out  2  00 illegal opcode, 01 illegal funct3, 10 ECALL/EBREAK
fault  out  1  sticky bus-timeout indication

Behaviour:
- State register and timeout counter are cleared asynchronously on rst=0.
  - After reset: state = FETCH, counter = 0, trap_cause = 00, fault = 0.
- All outputs are Moore/Mealy combinational from state and inputs. Every output defaults to 0 in every state unless listed below.
- FETCH:
  - Always drives mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, alu_op=00.
  - IRWrite and PCWrite are asserted only in the cycle where mem_ready=1; next state is then DECODE. Otherwise the FSM stays in FETCH.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01, alu_op=00 (precomputes the branch target into ALUOut).
  - Dispatch on opcode:
    - R-type 0110011 -> EXEC_R
    - I-type ALU 0010011 -> EXEC_I
    - load 0000011 -> MEM_ADDR, only if funct3 is 000/001/010/100/101
    - store 0100011 -> MEM_ADDR, only if funct3 is 000/001/010
    - branch 1100011 -> BRANCH, only if funct3 is not 010/011
    - JAL 1101111 -> JAL
    - JALR 1100111 -> JALR_ADDR
    - LUI 0110111 -> LUI
    - AUIPC 0010111 -> AUIPC
    - FENCE 0001111 -> FETCH
    - SYSTEM 1110011 -> TRAP with cause 10
    - Bad funct3 on load/store/branch -> TRAP with cause 01
    - Any other opcode -> TRAP with cause 00
  - trap_cause is latched on the DECODE->TRAP transition.
  - With TRAP_ON_ILLEGAL=0, every TRAP destination becomes FETCH and trap_cause is not updated.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, alu_op=10 -> ALU_WB.
- EXEC_I: ALUSrcA=10, ALUSrcB=01, alu_op=10 -> ALU_WB.
- LUI: ALUSrcB=01, alu_op=10 -> ALU_WB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, alu_op=10 -> ALU_WB.
- ALU_WB: ResultSrc=00, RegWrite=1 -> FETCH.
- JALR_ADDR: ALUSrcA=10, ALUSrcB=01, alu_op=00 -> JAL.
- JAL:
  - Drives PCWrite=1, ResultSrc=00 (PC <= ALUOut target), ALUSrcA=01, ALUSrcB=10, alu_op=00 (ALU computes the link address old PC+4).
  - Next state ALU_WB, which writes the link register.
- BRANCH:
  - Drives ALUSrcA=10, ALUSrcB=00, alu_op=01, ResultSrc=00.
  - PCWrite = taken, where taken is selected by funct3:
    - 000: zero
    - 001: !zero
    - 100: lt
    - 101: !lt
    - 110: ltu
    - 111: !ltu
  - Next state FETCH.
- MEM_ADDR:
  - Drives ALUSrcA=10, ALUSrcB=01, alu_op=00.
  - Next state MEM_WRITE for a store opcode, otherwise MEM_READ.
- MEM_READ:
  - Drives mem_req=1, AdrSrc=1, mem_size=funct3[1:0], mem_unsigned=funct3[2].
  - Goes to MEM_WB on mem_ready, otherwise holds.
- MEM_WRITE:
  - Same outputs as MEM_READ, plus MemWrite=1 for every cycle the state is held.
  - Goes to FETCH on mem_ready, otherwise holds.
- MEM_WB: ResultSrc=01, RegWrite=1, mem_size and mem_unsigned held -> FETCH.
- Timeout (FETCH, MEM_READ, MEM_WRITE):
  - The counter clears on entry to each of these states and increments on each cycle with mem_ready=0.
  - If the counter == MEM_TIMEOUT-1 and mem_ready=0, the next state is FAULT.
  - mem_ready=1 in that same cycle wins, and the access completes normally.
- FAULT: fault=1, all other outputs 0. Terminal state; only rst exits it.
- TRAP: PCWrite=1, ResultSrc=11, trap=1 for exactly 1 cycle -> FETCH.
- Reset asserted mid-access immediately forces FETCH, and all enables drop in the same cycle.

Test Plan:
- ADD (opcode 0110011), mem_ready tied 1 -> state sequence FETCH, DECODE, EXEC_R, ALU_WB (RegWrite=1), FETCH; 4 cycles total.
- BLT with lt=1, then BGEU with ltu=1 -> PCWrite=1 in BRANCH for the BLT; PCWrite=0 for the BGEU.
- LHU (funct3 101), mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles with mem_size=01 and mem_unsigned=1, then MEM_WB with ResultSrc=01 and RegWrite=1.
- Store with funct3 011 -> TRAP, trap=1 for 1 cycle, trap_cause=01, PCWrite=1 with ResultSrc=11, then FETCH. Repeat with TRAP_ON_ILLEGAL=0 -> DECODE goes straight to FETCH, trap stays 0.
- MEM_TIMEOUT=16, mem_ready held 0 in FETCH -> fault=1 after 16 cycles, all other outputs 0; rst low then high -> FETCH with fault=0.
- JALR -> JALR_ADDR (ALUSrcA=10, ALUSrcB=01), then JAL (PCWrite=1, ALUSrcB=10), then ALU_WB (RegWrite=1).
